branch_sequencer: RTL and testbench

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

---
 rtl/branch_sequencer.sv | 166 ++++++++++++++++
 tb/tb_branch_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// Branch sequencer: decodes B/BL/CBZ/CBNZ/B.cond and steps through the
// LINK/TEST/BRANCH cycles, emitting a 33-bit datapath control word per cycle.
module branch_sequencer #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned LINK_REG = 30,
  parameter int unsigned COND_EN  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       I,
  input  logic [4:0]        status,
  output logic [32:0]       cw,
  output logic [DATA_W-1:0] K,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LINK   = 2'b01,
    S_TEST   = 2'b10,
    S_BRANCH = 2'b11
  } state_t;

  typedef enum logic [2:0] {
    OP_B, OP_BL, OP_CBZ, OP_CBNZ, OP_BCOND, OP_NONE
  } op_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  op_t         op_q;

  logic       alu_en, alu_bs, rf_b_en, rf_w, ram_en, ram_w, pc_en, pc_is, status_ld;
  logic [4:0] alu_fs, rf_sa, rf_sb, rf_da;
  logic [1:0] pc_fs;

  function automatic op_t decode(input logic [31:0] w);
    if (w[31:26] == 6'b000101) return OP_B;
    if (w[31:26] == 6'b100101) return OP_BL;
    if (w[31:24] == 8'b10110100) return OP_CBZ;
    if (w[31:24] == 8'b10110101) return OP_CBNZ;
    if (COND_EN != 0 && w[31:24] == 8'b01010100 && !w[4]) return OP_BCOND;
    return OP_NONE;
  endfunction

  // status = {live_zero, V, C, N, Z}; only the stored flags feed B.cond
  function automatic logic cond_true(input logic [3:0] c, input logic [4:0] s);
    logic v, cf, n, z;
    {v, cf, n, z} = s[3:0];
    unique case (c)
      4'h0: return z;
      4'h1: return ~z;
      4'h2: return cf;
      4'h3: return ~cf;
      4'h4: return n;
      4'h5: return ~n;
      4'h6: return v;
      4'h7: return ~v;
      4'h8: return cf & ~z;
      4'h9: return ~(cf & ~z);
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return ~z & (n == v);
      4'hD: return ~(~z & (n == v));
      default: return 1'b1;
    endcase
  endfunction

  assign op_q = decode(instr_q);

  always_comb begin
    unique case (op_q)
      OP_B, OP_BL:                K = {{(DATA_W-26){instr_q[25]}}, instr_q[25:0]};
      OP_CBZ, OP_CBNZ, OP_BCOND:  K = {{(DATA_W-19){instr_q[23]}}, instr_q[23:5]};
      default:                    K = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    alu_en    = 1'b0;
    alu_bs    = 1'b0;
    alu_fs    = 5'b11111;
    rf_b_en   = 1'b0;
    rf_sa     = 5'd31;
    rf_sb     = 5'd31;
    rf_da     = 5'd0;
    rf_w      = 1'b0;
    ram_en    = 1'b0;
    ram_w     = 1'b0;
    pc_en     = 1'b0;
    pc_fs     = 2'b00;
    pc_is     = 1'b0;
    status_ld = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          instr_d = I;
          unique case (decode(I))
            OP_B:            state_d = S_BRANCH;
            OP_BL:           state_d = S_LINK;
            OP_CBZ, OP_CBNZ: state_d = S_TEST;
            OP_BCOND: begin
              // B.cond resolves in the start cycle from the stored flags
              if (cond_true(I[3:0], status)) begin
                state_d = S_BRANCH;
              end else begin
                done  = 1'b1;
                pc_fs = 2'b01;
              end
            end
            default: begin
              done = 1'b1;
              err  = 1'b1;
            end
          endcase
        end
      end
      S_LINK: begin
        pc_en   = 1'b1;
        rf_da   = 5'(LINK_REG);
        rf_w    = 1'b1;
        state_d = S_BRANCH;
      end
      S_TEST: begin
        alu_en  = 1'b1;
        alu_fs  = 5'b00100;
        rf_b_en = 1'b1;
        rf_sb   = instr_q[4:0];
        if ((op_q == OP_CBZ) ? status[4] : ~status[4]) begin
          state_d = S_BRANCH;
        end else begin
          done    = 1'b1;
          pc_fs   = 2'b01;
          state_d = S_IDLE;
        end
      end
      S_BRANCH: begin
        pc_fs   = 2'b11;
        pc_is   = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign cw   = {alu_en, alu_bs, alu_fs, rf_b_en, rf_sa, rf_sb, rf_da, rf_w,
                 ram_en, ram_w, pc_en, pc_fs, pc_is, status_ld, state_d};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed scenarios plus randomized instructions
// checked cycle by cycle against an instruction-level reference model.
module tb_branch_sequencer;

  localparam int unsigned DW = 64;
  localparam logic [32:0] IDLE_CW = {1'b0, 1'b0, 5'h1F, 1'b0, 5'd31, 5'd31, 5'd0,
                                     1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};

  logic          clock, reset, start, busy, done, err;
  logic [31:0]   I;
  logic [4:0]    status;
  logic [32:0]   cw;
  logic [DW-1:0] K;

  int vectors = 0;
  int miscompares = 0;

  branch_sequencer #(.DATA_W(DW), .LINK_REG(30), .COND_EN(1)) dut (
    .clock(clock), .reset(reset), .start(start), .I(I), .status(status),
    .cw(cw), .K(K), .busy(busy), .done(done), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {busy, done, err, alu_en, rf_w, pc_en, pc_fs[1:0], pc_is, ram_w, status_ld, next_state[1:0]}
  function automatic logic [12:0] obs_vec();
    return {busy, done, err, cw[32], cw[9], cw[6], cw[5:4], cw[3], cw[7], cw[2], cw[1:0]};
  endfunction

  function automatic logic [12:0] mk(bit b, bit d, bit e, bit alu, bit rfw, bit pce,
                                     bit [1:0] fs, bit is, bit [1:0] ns);
    return {b, d, e, alu, rfw, pce, fs, is, 1'b0, 1'b0, ns};
  endfunction

  function automatic bit cond_ok(bit [3:0] c, bit v, bit cf, bit n, bit z);
    bit b;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cf;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cf && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    return (c[0] && c != 4'hF) ? !b : b;
  endfunction

  task automatic issue(input logic [31:0] w, input logic [4:0] st);
    @(posedge clock); #1;
    start = 1'b1; I = w; status = st;
    @(negedge clock);
  endtask

  task automatic cyc();
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; I = '0; status = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++;
    if ({busy, done, err} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 000", {busy, done, err});
    end
    vectors++;
    if (cw !== IDLE_CW || K !== '0) begin
      miscompares++; $display("FAIL reset_cw_k: got cw=%h K=%h expected cw=%h K=0", cw, K, IDLE_CW);
    end
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic test_bl();
    issue(32'h94000010, 5'd0);
    vectors++;
    if ({done, cw[1:0]} !== 3'b001) begin
      miscompares++; $display("FAIL bl_start: got done/ns=%b expected 001", {done, cw[1:0]});
    end
    cyc();
    vectors++;
    if ({busy, cw[14:10], cw[9], cw[6], cw[5:4], done} !== {1'b1, 5'd30, 1'b1, 1'b1, 2'b00, 1'b0}
        || K !== 64'd16) begin
      miscompares++; $display("FAIL bl_link: got da=%0d w=%b pcen=%b fs=%b done=%b K=%0d expected da=30 w=1 pcen=1 fs=00 done=0 K=16",
                              cw[14:10], cw[9], cw[6], cw[5:4], done, K);
    end
    cyc();
    vectors++;
    if ({cw[5:4], cw[3], done, cw[9]} !== 5'b11110 || K !== 64'd16) begin
      miscompares++; $display("FAIL bl_branch: got fs=%b is=%b done=%b w=%b K=%0d expected 11 1 1 0 16",
                              cw[5:4], cw[3], done, cw[9], K);
    end
    cyc();
  endtask

  task automatic test_b_neg();
    issue(32'h17FFFFFF, 5'd0);
    vectors++;
    if ({busy, done, cw[1:0]} !== 4'b0011) begin
      miscompares++; $display("FAIL b_start: got %b expected 0011", {busy, done, cw[1:0]});
    end
    cyc();
    vectors++;
    if (K !== '1 || {cw[5:4], done} !== 3'b111) begin
      miscompares++; $display("FAIL b_branch: got K=%h fs=%b done=%b expected K=all ones fs=11 done=1", K, cw[5:4], done);
    end
    cyc();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL b_after: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_cbz();
    issue(32'hB4000043, 5'b10000);
    cyc();
    vectors++;
    if ({cw[32], cw[30:26], cw[24:20], cw[19:15], cw[9], done, cw[1:0]} !==
        {1'b1, 5'b00100, 5'd31, 5'd3, 1'b0, 1'b0, 2'b11} || K !== 64'd2) begin
      miscompares++; $display("FAIL cbz_taken_test: got alu=%b fs=%b sa=%0d sb=%0d w=%b done=%b ns=%b K=%0d expected 1 00100 31 3 0 0 11 2",
                              cw[32], cw[30:26], cw[24:20], cw[19:15], cw[9], done, cw[1:0], K);
    end
    cyc();
    vectors++;
    if ({cw[5:4], done} !== 3'b111) begin
      miscompares++; $display("FAIL cbz_taken_branch: got fs=%b done=%b expected 11 1", cw[5:4], done);
    end
    cyc();
    issue(32'hB4000043, 5'b00000);
    cyc();
    vectors++;
    if ({done, cw[5:4], cw[1:0]} !== 5'b10100) begin
      miscompares++; $display("FAIL cbz_nt_test: got done=%b fs=%b ns=%b expected 1 01 00", done, cw[5:4], cw[1:0]);
    end
    cyc();
    vectors++;
    if ({busy, done, cw[5:4]} !== 4'b0000) begin
      miscompares++; $display("FAIL cbz_nt_after: got busy=%b done=%b fs=%b expected 0 0 00", busy, done, cw[5:4]);
    end
  endtask

  task automatic test_bcond();
    issue(32'h5400004C, 5'b01010);
    vectors++;
    if ({busy, done, cw[1:0]} !== 4'b0011) begin
      miscompares++; $display("FAIL bgt_taken: got %b expected 0011", {busy, done, cw[1:0]});
    end
    cyc();
    vectors++;
    if ({done, cw[5:4]} !== 3'b111 || K !== 64'd2) begin
      miscompares++; $display("FAIL bgt_branch: got done=%b fs=%b K=%0d expected 1 11 2", done, cw[5:4], K);
    end
    cyc();
    issue(32'h5400004C, 5'b01011);
    vectors++;
    if ({busy, done, err, cw[5:4], cw[1:0]} !== 7'b0100100) begin
      miscompares++; $display("FAIL bgt_not_taken: got %b expected 0100100", {busy, done, err, cw[5:4], cw[1:0]});
    end
    cyc();
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++; $display("FAIL bgt_after: got %b expected 00", {busy, done});
    end
  endtask

  task automatic test_unsupported();
    issue(32'hD503201F, 5'b11111);
    vectors++;
    if ({done, err, cw[9], cw[6], busy, cw[1:0]} !== 7'b1100000) begin
      miscompares++; $display("FAIL unsup: got %b expected 1100000", {done, err, cw[9], cw[6], busy, cw[1:0]});
    end
    cyc();
    vectors++;
    if ({done, err, busy} !== 3'b000) begin
      miscompares++; $display("FAIL unsup_after: got %b expected 000", {done, err, busy});
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) issue(32'h94000010, 5'd0);
      else        issue(32'hB4000043, 5'b10000);
      cyc();
      reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      @(negedge clock);
      vectors++;
      if ({busy, done, err} !== 3'b000 || cw !== IDLE_CW || K !== '0) begin
        miscompares++; $display("FAIL reset_mid%0d: got busy=%b done=%b err=%b cw=%h K=%h expected idle", k, busy, done, err, cw, K);
      end
      cyc();
      vectors++;
      if (cw[5:4] === 2'b11 || cw[9] !== 1'b0 || busy !== 1'b0) begin
        miscompares++; $display("FAIL reset_mid_nobranch%0d: got fs=%b w=%b busy=%b expected no branch", k, cw[5:4], cw[9], busy);
      end
    end
  endtask

  task automatic test_back_to_back_busy();
    issue(32'h94000010, 5'd0);
    @(posedge clock); #1 start = 1'b1; I = 32'hD503201F;
    @(negedge clock);
    vectors++;
    if ({err, done, cw[9]} !== 3'b001) begin
      miscompares++; $display("FAIL busy_ignore_link: got err=%b done=%b w=%b expected 0 0 1", err, done, cw[9]);
    end
    @(posedge clock); #1 I = 32'hB4000003;
    @(negedge clock);
    vectors++;
    if ({cw[5:4], done, err} !== 4'b1110) begin
      miscompares++; $display("FAIL busy_ignore_branch: got fs=%b done=%b err=%b expected 11 1 0", cw[5:4], done, err);
    end
    cyc();
    vectors++;
    if (busy !== 1'b0 || K !== 64'd16) begin
      miscompares++; $display("FAIL busy_ignore_capture: got busy=%b K=%0d expected 0 16", busy, K);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [12:0] q[$];
      logic [31:0] w;
      logic [4:0]  st;
      logic [63:0] kexp;
      int          t;
      bit          kchk, taken;
      longint      kv;
      t    = $urandom_range(0, 6);
      st   = 5'($urandom);
      w    = $urandom;
      kchk = 1'b1;
      case (t)
        0: w[31:26] = 6'b000101;
        1: w[31:26] = 6'b100101;
        2: w[31:24] = 8'hB4;
        3: w[31:24] = 8'hB5;
        4: begin w[31:24] = 8'h54; w[4] = 1'b0; end
        5: w[31:24] = 8'hFF;
        default: begin w[31:24] = 8'h54; w[4] = 1'b1; end
      endcase
      if (t <= 1) begin
        kv = longint'(w[25:0]);
        if (w[25]) kv = kv - (longint'(1) << 26);
      end else begin
        kv = longint'(w[23:5]);
        if (w[23]) kv = kv - (longint'(1) << 19);
      end
      kexp = 64'(kv);
      case (t)
        0: begin
          q.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11));
          q.push_back(mk(1, 1, 0, 0, 0, 0, 2'b11, 1, 2'b00));
        end
        1: begin
          q.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01));
          q.push_back(mk(1, 0, 0, 0, 1, 1, 2'b00, 0, 2'b11));
          q.push_back(mk(1, 1, 0, 0, 0, 0, 2'b11, 1, 2'b00));
        end
        2, 3: begin
          taken = (t == 2) ? st[4] : !st[4];
          q.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10));
          if (taken) begin
            q.push_back(mk(1, 0, 0, 1, 0, 0, 2'b00, 0, 2'b11));
            q.push_back(mk(1, 1, 0, 0, 0, 0, 2'b11, 1, 2'b00));
          end else begin
            q.push_back(mk(1, 1, 0, 1, 0, 0, 2'b01, 0, 2'b00));
          end
        end
        4: begin
          if (cond_ok(w[3:0], st[3], st[2], st[1], st[0])) begin
            q.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11));
            q.push_back(mk(1, 1, 0, 0, 0, 0, 2'b11, 1, 2'b00));
          end else begin
            q.push_back(mk(0, 1, 0, 0, 0, 0, 2'b01, 0, 2'b00));
          end
        end
        default: begin
          kchk = 1'b0;
          q.push_back(mk(0, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00));
        end
      endcase
      issue(w, st);
      foreach (q[c]) begin
        if (c > 0) begin
          @(posedge clock); #1;
          start = 1'($urandom);
          I     = $urandom;
          @(negedge clock);
        end
        vectors++;
        if (obs_vec() !== q[c] || (c > 0 && K !== kexp)) begin
          miscompares++;
          $display("FAIL rand_cycle: instr=%h cyc=%0d got %b K=%h expected %b K=%h", w, c, obs_vec(), K, q[c], kexp);
        end
      end
      cyc();
      vectors++;
      if (cw !== IDLE_CW || {busy, done, err} !== 3'b000 || (kchk && K !== kexp)) begin
        miscompares++;
        $display("FAIL rand_idle: instr=%h got cw=%h flags=%b K=%h expected cw=%h flags=000 K=%h", w, cw, {busy, done, err}, K, IDLE_CW, kexp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bl();
    test_b_neg();
    test_cbz();
    test_bcond();
    test_unsupported();
    test_reset_mid();
    test_back_to_back_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
